// File: rtl/wb_result_queue_if.sv
// Shared side-result type and the push/pop handshake bundle for the
// writeback result queue (execution unit on the in side, arbiter on the out side).
package wb_result_queue_pkg;

  typedef struct packed {
    logic        cr0_valid;
    logic [3:0]  cr0;
    logic        xer_valid;
    logic [31:0] xer;
  } cond_exception_t;

endpackage

interface wb_result_queue_if #(
  parameter int RS_ID_WIDTH = 5
);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [RS_ID_WIDTH-1:0]                 in_rs_id;
  logic [4:0]                             in_reg_addr;
  logic [31:0]                            in_result;
  wb_result_queue_pkg::cond_exception_t   in_cr0_xer;

  logic                                   out_valid;
  logic                                   out_ready;
  logic [RS_ID_WIDTH-1:0]                 out_rs_id;
  logic [4:0]                             out_reg_addr;
  logic [31:0]                            out_result;
  wb_result_queue_pkg::cond_exception_t   out_cr0_xer;

  // The queue itself is the slave; the environment drives the master side.
  modport slave (
    input  in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer,
    output in_ready,
    output out_valid, out_rs_id, out_reg_addr, out_result, out_cr0_xer,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer,
    input  in_ready,
    input  out_valid, out_rs_id, out_reg_addr, out_result, out_cr0_xer,
    output out_ready
  );

endinterface

// File: rtl/wb_result_queue.sv
// Circular-buffer FIFO holding execution-unit results until the writeback
// arbiter takes them; no bypass, flush discards everything.
module wb_result_queue
  import wb_result_queue_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  wb_result_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
    logic [31:0]            result;
    cond_exception_t        cr0_xer;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;
  entry_t          in_entry;
  entry_t          head_entry;

  // Handshake flags are held low throughout reset so nothing moves in or out.
  assign bus.in_ready  = ~rst && (count_q < CW'(DEPTH));
  assign bus.out_valid = ~rst && (count_q != '0);
  assign count         = rst ? '0 : count_q;
  assign almost_full   = (count >= CW'(AF_LEVEL));

  assign push = bus.in_valid  && bus.in_ready  && ~flush;
  assign pop  = bus.out_valid && bus.out_ready && ~flush;

  assign in_entry.rs_id    = bus.in_rs_id;
  assign in_entry.reg_addr = bus.in_reg_addr;
  assign in_entry.result   = bus.in_result;
  assign in_entry.cr0_xer  = bus.in_cr0_xer;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; contents are only meaningful under out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_entry;
  end

  assign head_entry       = mem[head];
  assign bus.out_rs_id    = head_entry.rs_id;
  assign bus.out_reg_addr = head_entry.reg_addr;
  assign bus.out_result   = head_entry.result;
  assign bus.out_cr0_xer  = head_entry.cr0_xer;

endmodule

// File: tb/tb_wb_result_queue.sv
// Scoreboard bench for wb_result_queue: directed scenarios then random traffic,
// checked against a queue-based occupancy/ordering model.
module tb_wb_result_queue;
  import wb_result_queue_pkg::*;

  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int RSW      = 5;

  typedef struct packed {
    logic [RSW-1:0]  rs_id;
    logic [4:0]      reg_addr;
    logic [31:0]     result;
    cond_exception_t cr0_xer;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;

  wb_result_queue_if #(.RS_ID_WIDTH(RSW)) bus ();

  wb_result_queue #(
    .RS_ID_WIDTH(RSW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF_LEVEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  item_t exp_q[$];
  item_t pend_item;
  item_t hd;
  bit    pend_push  = 1'b0;
  bit    pend_clear = 1'b0;
  bit    mon_on     = 1'b0;
  int    checks     = 0;
  int    passes     = 0;
  int    sz;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: retire last cycle's model effect, then drive this cycle's inputs.
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input logic [4:0] tag, input bit ordy);
    item_t it;
    @(negedge clk);
    if (pend_clear) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    it.rs_id             = tag;
    it.reg_addr          = 5'($urandom);
    it.result            = $urandom;
    it.cr0_xer.cr0_valid = 1'($urandom);
    it.cr0_xer.cr0       = 4'($urandom);
    it.cr0_xer.xer_valid = 1'($urandom);
    it.cr0_xer.xer       = $urandom;
    rst             = r;
    flush           = f;
    bus.in_valid    = v;
    bus.in_rs_id    = it.rs_id;
    bus.in_reg_addr = it.reg_addr;
    bus.in_result   = it.result;
    bus.in_cr0_xer  = it.cr0_xer;
    bus.out_ready   = ordy;
    pend_clear = r || f;
    pend_push  = v && !r && (exp_q.size() < DEPTH);
    pend_item  = it;
    mon_on     = 1'b1;
  endtask

  // Monitor: compares flags every cycle and the head entry whenever one is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        sz = exp_q.size();
        if (rst) begin
          checkOutput("rst_count", 64'(count), 64'd0);
          checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
          checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
          checkOutput("rst_almost_full", 64'(almost_full), 64'd0);
        end else begin
          checkOutput("count", 64'(count), 64'(sz));
          checkOutput("in_ready", 64'(bus.in_ready), 64'(sz < DEPTH));
          checkOutput("out_valid", 64'(bus.out_valid), 64'(sz != 0));
          checkOutput("almost_full", 64'(almost_full), 64'(sz >= AF_LEVEL));
          if (sz != 0 && bus.out_valid) begin
            hd = exp_q[0];
            checkOutput("out_rs_id", 64'(bus.out_rs_id), 64'(hd.rs_id));
            checkOutput("out_reg_addr", 64'(bus.out_reg_addr), 64'(hd.reg_addr));
            checkOutput("out_result", 64'(bus.out_result), 64'(hd.result));
            checkOutput("out_cr0_xer", 64'(bus.out_cr0_xer), 64'(hd.cr0_xer));
            if (bus.out_ready && !flush) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_rs_id    = '0;
    bus.in_reg_addr = '0;
    bus.in_result   = '0;
    bus.in_cr0_xer  = '0;

    applyStimulus(1, 0, 0, 5'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 0);

    // Three pushes with the arbiter stalled, then a hold cycle.
    applyStimulus(0, 0, 1, 5'd1, 0);
    applyStimulus(0, 0, 1, 5'd2, 0);
    applyStimulus(0, 0, 1, 5'd3, 0);
    applyStimulus(0, 0, 0, 5'd0, 0);

    // Fill, then offer a push on a pop cycle while full.
    applyStimulus(0, 0, 1, 5'd4, 0);
    applyStimulus(0, 0, 1, 5'd9, 1);
    applyStimulus(0, 0, 0, 5'd0, 0);

    // Drop to two entries, then push 7 alongside a pop.
    applyStimulus(0, 0, 0, 5'd0, 1);
    applyStimulus(0, 0, 1, 5'd7, 1);
    applyStimulus(0, 0, 0, 5'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 5'd0, 1);

    // Six pushes with interleaved pops to wrap the pointers.
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 5'(10 + i), i[0]);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 5'd0, 1);

    // Flush at count 3 alongside a push and a pop.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 5'(20 + i), 0);
    applyStimulus(0, 1, 1, 5'd30, 1);
    applyStimulus(0, 0, 0, 5'd0, 1);
    applyStimulus(0, 0, 0, 5'd0, 1);

    // Reset at count 2 with a push pending.
    applyStimulus(0, 0, 1, 5'd24, 0);
    applyStimulus(0, 0, 1, 5'd25, 0);
    applyStimulus(1, 0, 1, 5'd26, 1);
    applyStimulus(0, 0, 0, 5'd0, 1);
    applyStimulus(0, 0, 1, 5'd27, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 9) < 6), 5'($urandom), 1'($urandom));
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 5'd0, 1);

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_result_queue.md
WB_RESULT_QUEUE -- requirements
Module: wb_result_queue

Interface
REQ-001 Parameter RS_ID_WIDTH, default 5, SHALL set the width of the reservation-station tag.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two, 2 or greater.
REQ-003 Parameter AF_LEVEL, default 3, SHALL set the occupancy at or above which almost_full asserts; legal range is 1..DEPTH.
REQ-004 clk  in  1  clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  synchronous discard of all queued entries.
REQ-007 in_valid  in  1  execution unit presents a result.
REQ-008 in_ready  out  1  queue accepts the presented result this cycle.
REQ-009 in_rs_id  in  RS_ID_WIDTH  reservation-station tag of the result.
REQ-010 in_reg_addr  in  5  GPR target address.
REQ-011 in_result  in  32  GPR result value.
REQ-012 in_cr0_xer  in  cond_exception_t  CR0/XER side results, including CR0_valid, xer_valid and xer.
REQ-013 out_valid  out  1  head entry is available; wired to the arbiter's gpr_input_valid slot.
REQ-014 out_ready  in  1  arbiter consumes the head entry this cycle.
REQ-015 out_rs_id, out_reg_addr, out_result, out_cr0_xer  out  same widths as inputs  head-entry fields.
REQ-016 count  out  clog2(DEPTH)+1  current occupancy.
REQ-017 almost_full  out  1  asserted when count is at least AF_LEVEL; used by issue to stall the unit.

Function
REQ-018 Storage SHALL be a circular buffer with head and tail pointers of clog2(DEPTH) bits; pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; the entry is written at tail and tail increments.
REQ-020 Pop SHALL occur on a cycle with out_valid=1 and out_ready=1; head increments.
REQ-021 in_ready SHALL be (count < DEPTH) and SHALL NOT depend combinationally on out_ready, so a full queue accepts no push even on a pop cycle.
REQ-022 out_valid SHALL be (count != 0) and SHALL NOT depend combinationally on in_valid; there is no same-cycle bypass, giving a minimum latency of 1 cycle from push to out_valid.
REQ-023 out_* fields SHALL be driven from the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_ready while out_valid=0 SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; the pushed entry SHALL be stored after the remaining entries.
REQ-026 Count updates: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-027 Entries SHALL leave in strict FIFO order, with all fields carried unmodified, including CR0_valid and xer_valid.
REQ-028 flush=1 SHALL, on the next edge, set head=tail=0 and count=0.
REQ-029 Push and pop requests in the flush cycle SHALL be discarded; in_ready and out_valid keep their REQ-021/REQ-022 values in that cycle.
REQ-030 almost_full SHALL be combinational from count.

Reset
REQ-031 During rst=1: head=0, tail=0, count=0, out_valid=0, in_ready=0 and almost_full=0.
REQ-032 Storage contents need no reset; out_* data fields are don't-care while out_valid=0.
REQ-033 rst SHALL take priority over flush, push and pop; in-flight entries are lost.
REQ-034 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-035 After reset, push tags 1,2,3 with out_ready=0 -> count=3, almost_full=1 (AF_LEVEL=3), out_rs_id=1 held stable.
REQ-036 Fill to DEPTH=4 entries, then in_valid=1 with out_ready=1 -> in_ready=0, no push, one pop, count=3 next cycle.
REQ-037 count=2, push tag 7 and pop in the same cycle -> count stays 2; 7 emerges after the older entry.
REQ-038 Push 6 entries with interleaved pops (wrap-around) -> output tag sequence equals input sequence; reg_addr, result, xer and CR0_valid match bit-exactly.
REQ-039 count=3, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed entry never appears.
REQ-040 rst asserted with count=2 and a push pending -> next cycle count=0, out_valid=0, in_ready=0; after release, in_ready=1.
